// File: rtl/tile_update_ctrl_pkg.sv
// tile_update_ctrl_pkg: tile codes, map geometry and shared types for the tile-update path.
package tile_update_ctrl_pkg;
    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 12;
    localparam logic [5:0] TILE_B  = 6'd0;
    localparam logic [5:0] TILE_D  = 6'd3;
    localparam logic [5:0] TILE_J  = 6'd9;
    localparam logic [5:0] TILE_GY = 6'd28;
    localparam logic [5:0] TILE_DY = 6'd34;
    typedef enum logic [1:0] {IDLE, WRITE, BUMP} state_t;
    typedef struct packed {
        logic [5:0] block;
        logic       point;
        logic [3:0] row;
        logic [5:0] col;
    } req_t;
endpackage

// File: rtl/tile_update_ctrl_bcd_counter4.sv
// bcd_counter4: 4-digit saturating BCD incrementer; rollover flags a 99->00 wrap of the low two digits.
module bcd_counter4 #(
    parameter logic [15:0] MAX = 16'h9999,
    parameter bit ROLL_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count,
    output logic        rollover
);
    logic [15:0] count_nx;
    logic [3:0] carry;
    logic sat;
    assign sat = count == MAX;
    assign carry[0] = 1'b1;
    assign carry[1] = count[3:0] == 4'd9;
    assign carry[2] = carry[1] && count[7:4] == 4'd9;
    assign carry[3] = carry[2] && count[11:8] == 4'd9;
    always_comb begin
        count_nx = count;
        for (int i = 0; i < 4; i++)
            count_nx[4*i +: 4] = carry[i] ? (count[4*i +: 4] == 4'd9 ? 4'd0 : count[4*i +: 4] + 4'd1) : count[4*i +: 4];
    end
    assign rollover = ROLL_EN && inc && !sat && count[7:0] == 8'h99;
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (inc && !sat)
            count <= count_nx;
    end
endmodule

// File: rtl/tile_update_ctrl.sv
// tile_update_ctrl: commits one tile-map write per resolver hit, keeps the BCD coin score, animates the bump.
// Define TILE_UPDATE_EXTRA_LIFE_EN to generate the extra_life pulse on every 100th coin.
module tile_update_ctrl
    import tile_update_ctrl_pkg::*;
#(
    parameter int BUMP_FRAMES = 8,
    parameter int BUMP_STEP = 2,
    parameter logic [15:0] SCORE_MAX = 16'h9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        req_valid,
    input  logic [5:0]  req_block,
    input  logic        req_point,
    input  logic [5:0]  req_col,
    input  logic [3:0]  req_row,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [5:0]  ram_wdata,
    output logic        busy,
    output logic        bump_active,
    output logic [5:0]  bump_col,
    output logic [3:0]  bump_row,
    output logic [4:0]  bump_offset,
    output logic [15:0] score_bcd,
    output logic        point_pulse,
    output logic        drop_pulse,
    output logic        extra_life
);
    localparam int SW = $clog2(BUMP_FRAMES);
`ifdef TILE_UPDATE_EXTRA_LIFE_EN
    localparam bit EXTRA_LIFE = 1'b1;
`else
    localparam bit EXTRA_LIFE = 1'b0;
`endif
    state_t state, state_nx;
    req_t cur, pend, incoming;
    logic pend_valid, prev_valid, new_req, launch, store, idle, last_step;
    logic [9:0] prev_addr;
    logic [SW-1:0] step, step_nx, mirror;
    logic [4:0] offset_nx;
    assign incoming = {req_block, req_point, req_row, req_col};
    // The resolver repeats a hit for several cycles; only a fresh address or a rising valid counts.
    assign new_req = req_valid && (!prev_valid || {req_row, req_col} != prev_addr);
    assign idle = state == IDLE;
    assign launch = idle && (pend_valid || new_req);
    assign store = new_req && (idle ? pend_valid : !pend_valid);
    assign last_step = frame_tick && step == SW'(BUMP_FRAMES - 1);
    assign step_nx = step + 1'b1;
    assign mirror = SW'(BUMP_FRAMES - 1) - step_nx;
    assign offset_nx = 5'((step_nx < mirror ? step_nx : mirror) * BUMP_STEP);
    assign ram_we = state == WRITE;
    assign ram_addr = {cur.row, cur.col};
    assign ram_wdata = cur.block;
    assign point_pulse = ram_we && cur.point;
    assign busy = !idle;
    assign bump_active = state == BUMP;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = launch ? WRITE : IDLE;
            WRITE:   state_nx = BUMP;
            BUMP:    state_nx = last_step ? IDLE : BUMP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur <= '0;
            pend <= '0;
            pend_valid <= 1'b0;
            prev_valid <= 1'b0;
            prev_addr <= '0;
            step <= '0;
            bump_offset <= '0;
            bump_row <= '0;
            bump_col <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state <= state_nx;
            prev_valid <= req_valid;
            prev_addr <= {req_row, req_col};
            pend_valid <= store || (pend_valid && !idle);
            drop_pulse <= new_req && !idle && pend_valid;
            if (store)
                pend <= incoming;
            if (launch)
                cur <= pend_valid ? pend : incoming;
            if (state == WRITE) begin
                bump_row <= cur.row;
                bump_col <= cur.col;
                step <= '0;
                bump_offset <= '0;
            end else if (state == BUMP && frame_tick) begin
                step <= step_nx;
                bump_offset <= last_step ? 5'd0 : offset_nx;
            end
        end
    end
    bcd_counter4 #(.MAX(SCORE_MAX), .ROLL_EN(EXTRA_LIFE)) u_score (
        .clk(clk),
        .rst_n(rst_n),
        .inc(point_pulse),
        .count(score_bcd),
        .rollover(extra_life)
    );
endmodule
